fixed2float: RTL

- Converts a 44-bit two's-complement fixed-point value back to IEEE-754 half precision (FP16).
- Sits on the accumulator output path of the neural processor. It is the inverse of the FP16-to-fixed front end: MAC results are summed in fixed point and re-packed to FP16 for writeback.
- 3-stage pipeline with a valid/ready handshake on both sides.

---
 rtl/fixed2float.sv | 96 +++++++++
 1 files changed

// File: rtl/fixed2float.sv
// fixed2float: 3-stage pipelined signed fixed-point (FIXED_W, FRAC_BITS) to FP16 converter.
//   Ports: clk, reset_n (async active-low)
//          fixed_in/valid_i/ready_o  - input handshake
//          float_out/valid_o/ready_i - output handshake, ovf_o flags saturated results
//   Optional: define FIXED2FLOAT_INF_EN to emit +/-infinity on overflow instead of +/-max finite.
module fixed2float #(
  parameter int FIXED_W   = 44,
  parameter int FRAC_BITS = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FIXED_W-1:0] fixed_in,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [15:0]        float_out,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               ovf_o
);
  localparam int PW = $clog2(FIXED_W);
  localparam int SUB_SH = 24 - FRAC_BITS;
`ifdef FIXED2FLOAT_INF_EN
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`else
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`endif
  logic               r1_v, r1_s, r2_v, r2_s, r2_z, r3_v, r_ovf;
  logic [FIXED_W-1:0] r1_m, r2_m;
  logic [PW-1:0]      r2_sh;
  logic signed [7:0]  r2_e;
  logic [15:0]        r_float;
  logic               w_stall;
  logic [FIXED_W-1:0] w_mag;
  logic [PW-1:0]      w_p;
  logic [FIXED_W-2:0] w_n;
  logic [9:0]         w_mant, w_smant;
  logic               w_g, w_st, w_up, w_sub, w_ovf;
  logic [10:0]        w_mr;
  logic signed [7:0]  w_er;
  logic [15:0]        w_float;
  assign w_stall   = r3_v & ~ready_i;
  assign ready_o   = ~w_stall;
  assign valid_o   = r3_v;
  assign float_out = r_float;
  assign ovf_o     = r_ovf;
  // Negating -2^(FIXED_W-1) yields the same bit pattern, which read unsigned is exactly 2^(FIXED_W-1).
  assign w_mag = fixed_in[FIXED_W-1] ? -fixed_in : fixed_in;
  always_comb begin
    w_p = '0;
    for (int i = 0; i < FIXED_W; i++) if (r1_m[i]) w_p = PW'(i);
  end
  // Left-justify so the leading one sits just above w_n; mantissa, guard and sticky are then fixed slices.
  assign w_n     = (FIXED_W-1)'(r2_m << r2_sh);
  assign w_mant  = w_n[FIXED_W-2 -: 10];
  assign w_g     = w_n[FIXED_W-12];
  assign w_st    = |w_n[FIXED_W-13:0];
  assign w_up    = w_g & (w_st | w_mant[0]);
  assign w_mr    = {1'b0, w_mant} + 11'(w_up);
  assign w_er    = r2_e + $signed({7'b0, w_mr[10]});
  assign w_sub   = r2_e < 8'sd1;
  assign w_smant = 10'(r2_m << SUB_SH);
  assign w_ovf   = ~r2_z & ~w_sub & (w_er > 8'sd30);
  assign w_float = r2_z  ? 16'h0000 :
                   w_ovf ? {r2_s, OVF_MAG} :
                   w_sub ? {r2_s, 5'b0, w_smant} :
                           {r2_s, w_er[4:0], w_mr[9:0]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_v    <= 1'b0;
      r1_s    <= 1'b0;
      r1_m    <= '0;
      r2_v    <= 1'b0;
      r2_s    <= 1'b0;
      r2_z    <= 1'b1;
      r2_m    <= '0;
      r2_sh   <= '0;
      r2_e    <= '0;
      r3_v    <= 1'b0;
      r_float <= '0;
      r_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r1_v    <= valid_i;
      r1_s    <= fixed_in[FIXED_W-1];
      r1_m    <= w_mag;
      r2_v    <= r1_v;
      r2_s    <= r1_s;
      r2_z    <= ~|r1_m;
      r2_m    <= r1_m;
      r2_sh   <= PW'(FIXED_W-1) - w_p;
      r2_e    <= $signed(8'(w_p)) + 8'sd15 - 8'(FRAC_BITS);
      r3_v    <= r2_v;
      r_float <= r2_v ? w_float : 16'h0000;
      r_ovf   <= r2_v & w_ovf;
    end
  end
endmodule
